pipelined_write_rx: RTL and testbench

//  Receive end of the pipelined-write link: samples one 10-bit link word per clock,

---
 rtl/pipelined_write_rx.sv | 211 +++++++++++++++++++++
 tb/tb_pipelined_write_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_write_rx.sv
// pipelined_write_rx
//   Sink end of the pipelined-write link. Each clock one link word is sampled. In the idle
//   state the word is a command; after a valid command the words are data cycles. Data beats
//   are staged, then the finished write is handed to a valid/ready output port. wdone pulses
//   follow the command's write type.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   link_dat   in   link word: cmd {rsvd[9:6], val[5], num_cycles[4:3], write_type[2:0]}
//                   or data {cycle_type[9:8], dat[7:0]}
//   out_vld    out  assembled write available
//   out_rdy    in   consumer accepts when out_vld && out_rdy
//   out_dat    out  payload, beat k in bits [8k+7:8k], unused beats zero
//   out_num    out  number of beats received (1..MAX_WR_CYCLES)
//   out_type   out  write type of the delivered write
//   wdone      out  one-cycle completion pulse
//   err_proto  out  one-cycle pulse: protocol violation, write dropped
//   err_ovfl   out  one-cycle pulse: write completed while output still held, write dropped
module pipelined_write_rx #(
    parameter int unsigned MAX_WR_CYCLES = 4,
    parameter int unsigned WR_WIDTH      = 8,
    parameter int unsigned CT_W          = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CT_W+WR_WIDTH-1:0]          link_dat,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] out_dat,
    output logic [2:0]                        out_num,
    output logic [2:0]                        out_type,
    output logic                              wdone,
    output logic                              err_proto,
    output logic                              err_ovfl
);

    localparam int unsigned OUT_W = MAX_WR_CYCLES * WR_WIDTH;
    localparam int unsigned NUM_W = $clog2(MAX_WR_CYCLES);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [CT_W-1:0] {
        CtIdle  = 2'd0,
        CtValid = 2'd1,
        CtDone  = 2'd2
    } cycle_type_e;

    typedef enum logic [2:0] {
        WtStd    = 3'd0,
        WtMulti  = 3'd1,
        WtSingle = 3'd2
    } write_type_e;

    typedef enum logic [0:0] {
        StIdle,
        StData
    } state_e;

    // Registered state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic [2:0]         type_q, type_d;
    logic [OUT_W-1:0]   stage_q, stage_d;
    logic               out_vld_q, out_vld_d;
    logic [OUT_W-1:0]   out_dat_q, out_dat_d;
    logic [2:0]         out_num_q, out_num_d;
    logic [2:0]         out_type_q, out_type_d;
    logic               wdone_q, wdone_d;
    logic               err_proto_q, err_proto_d;
    logic               err_ovfl_q, err_ovfl_d;

    // Command view of the link word
    logic               cmd_val;
    logic [NUM_W-1:0]   cmd_num;
    logic [2:0]         cmd_type;
    // Data view of the link word
    logic [CT_W-1:0]    dat_ct;
    logic [WR_WIDTH-1:0] dat_byte;

    logic [CNT_W-1:0]   cnt_inc;
    logic [OUT_W-1:0]   stage_ins;
    logic               complete;

    assign cmd_val  = link_dat[5];
    assign cmd_num  = link_dat[4:3];
    assign cmd_type = link_dat[2:0];
    assign dat_ct   = link_dat[CT_W+WR_WIDTH-1:WR_WIDTH];
    assign dat_byte = link_dat[WR_WIDTH-1:0];

    assign cnt_inc   = cnt_q + 1'b1;
    // Staging is cleared at the command, so OR-ing the beat into its slot is enough.
    assign stage_ins = stage_q | (OUT_W'(dat_byte) << (cnt_q * WR_WIDTH));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        type_d      = type_q;
        stage_d     = stage_q;
        out_vld_d   = out_vld_q && !out_rdy;
        out_dat_d   = out_dat_q;
        out_num_d   = out_num_q;
        out_type_d  = out_type_q;
        wdone_d     = 1'b0;
        err_proto_d = 1'b0;
        err_ovfl_d  = 1'b0;
        complete    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_val) begin
                    if (cmd_type > WtSingle) begin
                        err_proto_d = 1'b1;
                    end else begin
                        exp_d   = (cmd_num == '0) ? CNT_W'(MAX_WR_CYCLES) : CNT_W'(cmd_num);
                        type_d  = cmd_type;
                        stage_d = '0;
                        cnt_d   = '0;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                case (dat_ct)
                    CtIdle: begin
                        // Bubble: hold everything.
                    end
                    CtValid: begin
                        if (cnt_inc < exp_q) begin
                            stage_d = stage_ins;
                            cnt_d   = cnt_inc;
                            wdone_d = (type_q == WtMulti);
                        end else begin
                            err_proto_d = 1'b1;
                            state_d     = StIdle;
                        end
                    end
                    CtDone: begin
                        if (cnt_inc == exp_q) begin
                            stage_d  = stage_ins;
                            cnt_d    = cnt_inc;
                            wdone_d  = (type_q == WtMulti) || (type_q == WtSingle);
                            complete = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            err_proto_d = 1'b1;
                            state_d     = StIdle;
                        end
                    end
                    default: begin
                        err_proto_d = 1'b1;
                        state_d     = StIdle;
                    end
                endcase
            end
            default: state_d = StIdle;
        endcase

        // A held, un-accepted write wins; the new one is dropped and flagged.
        if (complete) begin
            if (out_vld_q && !out_rdy) begin
                err_ovfl_d = 1'b1;
            end else begin
                out_vld_d  = 1'b1;
                out_dat_d  = stage_ins;
                out_num_d  = cnt_inc;
                out_type_d = type_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            exp_q       <= '0;
            type_q      <= '0;
            stage_q     <= '0;
            out_vld_q   <= 1'b0;
            out_dat_q   <= '0;
            out_num_q   <= '0;
            out_type_q  <= '0;
            wdone_q     <= 1'b0;
            err_proto_q <= 1'b0;
            err_ovfl_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            type_q      <= type_d;
            stage_q     <= stage_d;
            out_vld_q   <= out_vld_d;
            out_dat_q   <= out_dat_d;
            out_num_q   <= out_num_d;
            out_type_q  <= out_type_d;
            wdone_q     <= wdone_d;
            err_proto_q <= err_proto_d;
            err_ovfl_q  <= err_ovfl_d;
        end
    end

    assign out_vld   = out_vld_q;
    assign out_dat   = out_dat_q;
    assign out_num   = out_num_q;
    assign out_type  = out_type_q;
    assign wdone     = wdone_q;
    assign err_proto = err_proto_q;
    assign err_ovfl  = err_ovfl_q;

endmodule

// File: tb/tb_pipelined_write_rx.sv
// tb_pipelined_write_rx
//   Self-checking bench for pipelined_write_rx. Inputs change on the falling edge, the DUT
//   samples on the rising edge and outputs are compared on the following falling edge.
//   Delivered writes are checked against a scoreboard queue filled when DONE words are driven.
module tb_pipelined_write_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  link_dat;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_dat;
    logic [2:0]  out_num;
    logic [2:0]  out_type;
    logic        wdone;
    logic        err_proto;
    logic        err_ovfl;

    always #5 clk = ~clk;

    pipelined_write_rx #(
        .MAX_WR_CYCLES(4),
        .WR_WIDTH     (8),
        .CT_W         (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link_dat (link_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_dat  (out_dat),
        .out_num  (out_num),
        .out_type (out_type),
        .wdone    (wdone),
        .err_proto(err_proto),
        .err_ovfl (err_ovfl)
    );

    localparam logic [1:0] CT_I = 2'd0, CT_V = 2'd1, CT_D = 2'd2, CT_X = 2'd3;
    localparam logic [2:0] STD = 3'd0, MULTI = 3'd1, SINGLE = 3'd2;
    // Flag nibble {out_vld, wdone, err_proto, err_ovfl}
    localparam logic [3:0] NONE = 4'b0000, FV = 4'b1000, FW = 4'b0100, FE = 4'b0010,
                           FO = 4'b0001;

    typedef struct {
        logic [31:0] dat;
        logic [2:0]  num;
        logic [2:0]  typ;
    } exp_t;

    typedef struct {
        logic [9:0] word;
        logic [3:0] flags;
        logic       push;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [9:0] cmd(input logic val, input logic [1:0] num,
                                       input logic [2:0] typ);
        return {4'b0000, val, num, typ};
    endfunction

    function automatic logic [9:0] dw(input logic [1:0] ct, input logic [7:0] b);
        return {ct, b};
    endfunction

    function automatic vec_t mk(input logic [9:0] w, input logic [3:0] f);
        vec_t v;
        v.word  = w;
        v.flags = f;
        v.push  = 1'b0;
        v.exp   = '{dat: 32'h0, num: 3'd0, typ: 3'd0};
        return v;
    endfunction

    function automatic vec_t mkp(input logic [9:0] w, input logic [3:0] f,
                                 input logic [31:0] d, input logic [2:0] n,
                                 input logic [2:0] t);
        vec_t v;
        v.word  = w;
        v.flags = f;
        v.push  = 1'b1;
        v.exp   = '{dat: d, num: n, typ: t};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_flags(input string name, input logic [3:0] exp);
        check(name, {28'h0, out_vld, wdone, err_proto, err_ovfl}, {28'h0, exp});
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] n, input logic [2:0] t);
        exp_t e;
        e.dat = d;
        e.num = n;
        e.typ = t;
        sb_q.push_back(e);
    endtask

    // Drive one word for one clock. A handshake seen now happens at the coming edge, so the
    // held write is popped from the scoreboard and compared here.
    task automatic cycle(input logic [9:0] word, input logic rdy);
        exp_t e;
        link_dat = word;
        out_rdy  = rdy;
        if (rst_n && out_vld && out_rdy) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: delivered %h with empty scoreboard", out_dat);
            end else begin
                e = sb_q.pop_front();
                check("sb_dat", out_dat, e.dat);
                check("sb_num", {29'h0, out_num}, {29'h0, e.num});
                check("sb_type", {29'h0, out_type}, {29'h0, e.typ});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        link_dat = '0;
        out_rdy  = 1'b0;

        // Table: every row applied with out_rdy=1.
        // Basic STD write, num=2.
        vecs.push_back(mk (cmd(1, 2'd2, STD),  NONE));
        vecs.push_back(mk (dw(CT_V, 8'h11),    NONE));
        vecs.push_back(mkp(dw(CT_D, 8'h22),    FV, 32'h0000_2211, 3'd2, STD));
        vecs.push_back(mk (10'h000,            NONE));
        // MULTI, num=0 means 4 beats, with a bubble.
        vecs.push_back(mk (cmd(1, 2'd0, MULTI), NONE));
        vecs.push_back(mk (dw(CT_V, 8'hA1),    FW));
        vecs.push_back(mk (dw(CT_I, 8'h00),    NONE));
        vecs.push_back(mk (dw(CT_V, 8'hA2),    FW));
        vecs.push_back(mk (dw(CT_V, 8'hA3),    FW));
        vecs.push_back(mkp(dw(CT_D, 8'hA4),    FV | FW, 32'hA4A3_A2A1, 3'd4, MULTI));
        // Back-to-back SINGLE write right after DONE.
        vecs.push_back(mk (cmd(1, 2'd1, SINGLE), NONE));
        vecs.push_back(mkp(dw(CT_D, 8'h5C),    FV | FW, 32'h0000_005C, 3'd1, SINGLE));
        // Early DONE on num=3: protocol error, then a clean write.
        vecs.push_back(mk (cmd(1, 2'd3, SINGLE), NONE));
        vecs.push_back(mk (dw(CT_V, 8'h01),    NONE));
        vecs.push_back(mk (dw(CT_D, 8'h02),    FE));
        vecs.push_back(mk (cmd(1, 2'd1, STD),  NONE));
        vecs.push_back(mkp(dw(CT_D, 8'h33),    FV, 32'h0000_0033, 3'd1, STD));
        // Illegal write_type, then val=0 with rsvd set.
        vecs.push_back(mk (cmd(1, 2'd0, 3'd5), FE));
        vecs.push_back(mk (10'h3DF,            NONE));
        vecs.push_back(mk (cmd(1, 2'd1, MULTI), NONE));
        vecs.push_back(mkp(dw(CT_D, 8'h7E),    FV | FW, 32'h0000_007E, 3'd1, MULTI));
        // VALID on the last beat, cycle_type 3, early DONE.
        vecs.push_back(mk (cmd(1, 2'd1, STD),  NONE));
        vecs.push_back(mk (dw(CT_V, 8'h10),    FE));
        vecs.push_back(mk (cmd(1, 2'd2, MULTI), NONE));
        vecs.push_back(mk (dw(CT_V, 8'h01),    FW));
        vecs.push_back(mk (dw(CT_X, 8'h00),    FE));
        vecs.push_back(mk (cmd(1, 2'd2, STD),  NONE));
        vecs.push_back(mk (dw(CT_D, 8'h05),    FE));
        vecs.push_back(mk (10'h000,            NONE));
        // Reserved bits set on a valid command are ignored.
        vecs.push_back(mk (10'h2A8,            NONE));
        vecs.push_back(mkp(dw(CT_D, 8'h66),    FV, 32'h0000_0066, 3'd1, STD));
        vecs.push_back(mk (10'h000,            NONE));

        // Reset with a word that would otherwise raise err_proto.
        @(negedge clk);
        cycle(cmd(1, 2'd0, 3'd5), 1'b1);
        cycle(cmd(1, 2'd0, 3'd5), 1'b1);
        check_flags("reset flags", NONE);
        check("reset out_dat", out_dat, 32'h0);
        check("reset out_num_type", {26'h0, out_num, out_type}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) sb_q.push_back(vecs[i].exp);
            cycle(vecs[i].word, 1'b1);
            check_flags($sformatf("vec[%0d] vld/wdone/eproto/eovfl", i), vecs[i].flags);
        end

        // Overflow: first write held, second dropped with err_ovfl.
        cycle(cmd(1, 2'd1, STD), 1'b0);
        push(32'h81, 3'd1, STD);
        cycle(dw(CT_D, 8'h81), 1'b0);
        check_flags("ovfl first held", FV);
        cycle(cmd(1, 2'd1, STD), 1'b0);
        cycle(dw(CT_D, 8'h82), 1'b0);
        check_flags("ovfl pulse", FV | FO);
        check("ovfl held dat", out_dat, 32'h81);
        cycle(10'h000, 1'b0);
        check_flags("ovfl still held", FV);
        check("ovfl held dat 2", out_dat, 32'h81);
        cycle(10'h000, 1'b1);
        check_flags("ovfl drained", NONE);

        // Completion on the same edge as the handshake of the held write.
        cycle(cmd(1, 2'd1, STD), 1'b0);
        push(32'h91, 3'd1, STD);
        cycle(dw(CT_D, 8'h91), 1'b0);
        cycle(cmd(1, 2'd1, STD), 1'b0);
        push(32'h92, 3'd1, STD);
        cycle(dw(CT_D, 8'h92), 1'b1);
        check_flags("swap vld stays", FV);
        check("swap new dat", out_dat, 32'h92);
        cycle(10'h000, 1'b1);
        check_flags("swap drained", NONE);

        // Reset mid-write after 2 of 4 beats; trailing DONE must be read as a null command.
        cycle(cmd(1, 2'd0, STD), 1'b1);
        cycle(dw(CT_V, 8'h01), 1'b1);
        cycle(dw(CT_V, 8'h02), 1'b1);
        rst_n = 1'b0;
        cycle(dw(CT_V, 8'h03), 1'b1);
        rst_n = 1'b1;
        check_flags("midreset flags", NONE);
        check("midreset out_dat", out_dat, 32'h0);
        cycle(dw(CT_D, 8'h44), 1'b1);
        check_flags("trailing done ignored", NONE);
        cycle(cmd(1, 2'd2, SINGLE), 1'b1);
        cycle(dw(CT_V, 8'h0A), 1'b1);
        check_flags("fresh valid no wdone", NONE);
        push(32'h0B0A, 3'd2, SINGLE);
        cycle(dw(CT_D, 8'h0B), 1'b1);
        check_flags("fresh done", FV | FW);
        cycle(10'h000, 1'b1);
        check_flags("fresh drained", NONE);

        check("scoreboard empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
